// File: rtl/lut_logic_engine_if.sv
// lut_logic_engine_if: stream-in, stream-out and table-write signals of the LUT engine
interface lut_logic_engine_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [N_IN-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [N_OUT-1:0] out_data;
   logic             cfg_we;
   logic [N_IN-1:0]  cfg_addr;
   logic [N_OUT-1:0] cfg_data;
   modport master (
      output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/lut_logic_engine.sv
// lut_logic_engine: two-stage pipelined, run-time rewritable truth-table lookup; LUT_STATS_EN adds a saturating transfer counter
module lut_logic_engine #(
   parameter int                          N_IN  = 4,
   parameter int                          N_OUT = 2,
   parameter logic [N_OUT*(2**N_IN)-1:0]  INIT  = 32'hA0FF1110
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef LUT_STATS_EN
   input  logic                 stat_clr,
   output logic [15:0]          stat_count,
`endif
   lut_logic_engine_if.slave    bus
);
   logic [N_OUT-1:0] lut_q [2**N_IN];
   logic             s1_valid;
   logic [N_IN-1:0]  s1_idx;
   logic             out_valid_q;
   logic [N_OUT-1:0] out_data_q;
   logic             advance;
   assign advance      = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid || advance;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   // table registers: INIT on reset, single-row write on cfg_we
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**N_IN; i++) lut_q[i] <= INIT[i*N_OUT +: N_OUT];
      end else if (bus.cfg_we) begin
         lut_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end
   // S1 captures the index whenever the slot is free or moving on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) s1_idx <= bus.in_data;
      end
   end
   // OUT registers the pre-write row so a same-edge write never leaks in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (advance) begin
         out_valid_q <= s1_valid;
         if (s1_valid) out_data_q <= lut_q[s1_idx];
      end
   end
`ifdef LUT_STATS_EN
   logic [15:0] stat_q;
   assign stat_count = stat_q;
   // count output transfers, saturating; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q <= '0;
      else if (stat_clr) stat_q <= '0;
      else if (out_valid_q && bus.out_ready && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
   end
`endif
endmodule

// File: tb/tb_lut_logic_engine.sv
// tb_lut_logic_engine: directed checks of the default 4x2 engine plus a randomised 3-in/5-out scoreboard run
module tb_lut_logic_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   lut_logic_engine_if #(.N_IN(4), .N_OUT(2)) bus ();
   lut_logic_engine_if #(.N_IN(3), .N_OUT(5)) bus2 ();
   localparam logic [39:0] INIT2 = 40'hC35A961E7B;
`ifdef LUT_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_count;
   logic        stat_clr2 = 1'b0;
   logic [15:0] stat_count2;
`endif
   lut_logic_engine dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef LUT_STATS_EN
      .stat_clr(stat_clr),
      .stat_count(stat_count),
`endif
      .bus(bus)
   );
   lut_logic_engine #(.N_IN(3), .N_OUT(5), .INIT(INIT2)) dut2 (
      .clk(clk),
      .rst_n(rst_n),
`ifdef LUT_STATS_EN
      .stat_clr(stat_clr2),
      .stat_count(stat_count2),
`endif
      .bus(bus2)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [1:0] exp1 [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0,
                                2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2, 2'd2};
      logic [4:0] m2 [8];
      logic [4:0] q2 [$];
      logic [39:0] init2;
      bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
      bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 1;
      bus2.cfg_we = 0; bus2.cfg_addr = 0; bus2.cfg_data = 0;
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1;
      tick();
      // 1: default table sweep
      bus.in_valid = 1; bus.in_data = 0;
      tick();
      check("sweep_lat", bus.out_valid, 0);
      for (int i = 1; i < 16; i++) begin
         bus.in_data = 4'(i);
         tick();
         check($sformatf("sweep_v%0d", i-1), bus.out_valid, 1);
         check($sformatf("sweep_d%0d", i-1), bus.out_data, 64'(exp1[i-1]));
      end
      bus.in_valid = 0;
      tick();
      check("sweep_d15", bus.out_data, 64'(exp1[15]));
      tick();
      check("sweep_drain", bus.out_valid, 0);
      // 2: backpressure
      bus.in_valid = 1; bus.in_data = 8;
      tick();
      bus.in_data = 9;
      tick();
      bus.in_valid = 0; bus.out_ready = 0;
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_hold_v", bus.out_valid, 1);
         check("bp_hold_d", bus.out_data, 3);
         check("bp_hold_rdy", bus.in_ready, 0);
      end
      bus.out_ready = 1;
      #1;
      check("bp_rel_rdy", bus.in_ready, 1);
      tick();
      check("bp_second_v", bus.out_valid, 1);
      check("bp_second_d", bus.out_data, 3);
      tick();
      check("bp_no_dup", bus.out_valid, 0);
      // 3: reprogram
      bus.cfg_we = 1; bus.cfg_addr = 5; bus.cfg_data = 2'b11;
      tick();
      bus.cfg_we = 0;
      bus.in_valid = 1; bus.in_data = 5;
      tick();
      bus.in_valid = 0;
      tick();
      check("cfg_new", bus.out_data, 3);
      bus.in_valid = 1; bus.in_data = 5;
      tick();
      bus.in_valid = 0;
      bus.cfg_we = 1; bus.cfg_addr = 5; bus.cfg_data = 2'b01;
      tick();
      bus.cfg_we = 0;
      check("cfg_same_edge_old", bus.out_data, 3);
      bus.in_valid = 1; bus.in_data = 5;
      tick();
      bus.in_valid = 0;
      tick();
      check("cfg_after", bus.out_data, 1);
      bus.cfg_we = 1; bus.cfg_addr = 6; bus.cfg_data = 2'b11;
      tick();
      bus.cfg_data = 2'b10;
      tick();
      bus.cfg_we = 0;
      bus.in_valid = 1; bus.in_data = 6;
      tick();
      bus.in_valid = 0;
      tick();
      check("cfg_last_wins", bus.out_data, 2);
      tick();
      // 4: async reset with two items in flight
      bus.in_valid = 1; bus.in_data = 8;
      tick();
      bus.in_data = 9;
      tick();
      bus.in_valid = 0; bus.out_ready = 0;
      #2;
      rst_n = 0;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_out_data", bus.out_data, 0);
      check("arst_in_ready", bus.in_ready, 1);
`ifdef LUT_STATS_EN
      check("arst_stat", stat_count, 0);
`endif
      #3;
      rst_n = 1;
      bus.out_ready = 1;
      tick();
      check("arst_flushed", bus.out_valid, 0);
      bus.in_valid = 1; bus.in_data = 5;
      tick();
      bus.in_valid = 0;
      tick();
      check("arst_init_row5", bus.out_data, 0);
      tick();
`ifdef LUT_STATS_EN
      // 5: saturating transfer counter
      stat_clr = 1;
      tick();
      stat_clr = 0;
      check("stat_clr", stat_count, 0);
      bus.in_valid = 1; bus.in_data = 3;
      for (int i = 0; i < 70002; i++) tick();
      check("stat_sat", stat_count, 16'hFFFF);
      stat_clr = 1;
      #1;
      check("stat_clr_xfer_live", bus.out_valid & bus.out_ready, 1);
      tick();
      stat_clr = 0;
      check("stat_clr_prio", stat_count, 0);
      bus.in_valid = 0;
      tick();
      tick();
      tick();
`endif
      // 6: N_IN=3, N_OUT=5 random scoreboard
      init2 = INIT2;
      for (int i = 0; i < 8; i++) m2[i] = init2[i*5 +: 5];
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 4; w++) begin
            bus2.cfg_we = 1;
            bus2.cfg_addr = 3'($urandom_range(0, 7));
            bus2.cfg_data = 5'($urandom_range(0, 31));
            m2[bus2.cfg_addr] = bus2.cfg_data;
            tick();
         end
         bus2.cfg_we = 0;
         for (int c = 0; c < 40; c++) begin
            if (c < 25) begin
               bus2.in_valid = 1'($urandom_range(0, 1));
               bus2.in_data = 3'($urandom_range(0, 7));
               bus2.out_ready = 1'($urandom_range(0, 1));
            end else begin
               bus2.in_valid = 0;
               bus2.out_ready = 1;
            end
            @(negedge clk);
            if (bus2.in_valid && bus2.in_ready) q2.push_back(m2[bus2.in_data]);
            if (bus2.out_valid && bus2.out_ready) begin
               if (q2.size() == 0) check("rnd_extra", bus2.out_valid, 0);
               else check("rnd_data", bus2.out_data, 64'(q2.pop_front()));
            end
            tick();
         end
         check("rnd_drained", q2.size(), 0);
         check("rnd_idle", bus2.out_valid, 0);
         q2.delete();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
